logic_frame_accum: RTL and testbench

Downstream consumer of the 4-bit bitwise logic stage (AND/OR/XOR units). Accepts one logic result per beat over a valid/ready handshake, reduces a frame of results into a summary (running XOR checksum, AND-reduce, OR-reduce, total ones count, beat count), and presents that summary on a held output handshake. It is the first sequential stage after the combinational logic units and feeds the result/status path.

---
 rtl/logic_frame_accum.sv | 120 ++++++++++++
 tb/tb_logic_frame_accum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_frame_accum.sv
// logic_frame_accum: reduces a frame of WIDTH-bit logic results into a summary
// (XOR checksum, AND/OR reduce, ones count, beat count) and presents it on a
// held valid/ready output handshake until downstream takes it.
module logic_frame_accum #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic [11:0]      out_ones,
  output logic [7:0]       out_count
);

  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_xor;
  logic [WIDTH-1:0] acc_and;
  logic [WIDTH-1:0] acc_or;
  logic [11:0]      acc_ones;
  logic [7:0]       acc_cnt;

  logic [11:0]      beat_ones;
  logic [WIDTH-1:0] nxt_xor;
  logic [WIDTH-1:0] nxt_and;
  logic [WIDTH-1:0] nxt_or;
  logic [11:0]      nxt_ones;
  logic [7:0]       nxt_cnt;
  logic             accept;
  logic             frame_end;

  // Ready is a pure decode of the state register, so it never depends on inputs.
  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (in_last || (nxt_cnt == FRAME_LEN_C));

  // Population count of the incoming beat.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives beat_ones and no latch is inferred.
    beat_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      beat_ones = beat_ones + {11'd0, in_data[i]};
    end
  end

  // Accumulator values including the current beat.
  always_comb begin
    nxt_xor  = acc_xor ^ in_data;
    nxt_and  = acc_and & in_data;
    nxt_or   = acc_or | in_data;
    nxt_ones = acc_ones + beat_ones;
    nxt_cnt  = acc_cnt + 8'd1;
  end

  // Frame FSM: accumulate beats, latch the summary on frame end, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc_xor   <= '0;
      acc_and   <= '1;
      acc_or    <= '0;
      acc_ones  <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_xor   <= '0;
      out_and   <= '0;
      out_or    <= '0;
      out_ones  <= '0;
      out_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      case (state)
        ACCUM: begin
          if (frame_end) begin
            out_xor   <= nxt_xor;
            out_and   <= nxt_and;
            out_or    <= nxt_or;
            out_ones  <= nxt_ones;
            out_count <= nxt_cnt;
            out_valid <= 1'b1;
            acc_xor   <= '0;
            acc_and   <= '1;
            acc_or    <= '0;
            acc_ones  <= '0;
            acc_cnt   <= '0;
            state     <= HOLD;
          end else if (accept) begin
            acc_xor  <= nxt_xor;
            acc_and  <= nxt_and;
            acc_or   <= nxt_or;
            acc_ones <= nxt_ones;
            acc_cnt  <= nxt_cnt;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_frame_accum.sv
// tb_logic_frame_accum: directed and randomized stimulus against a frame-level
// reference model (queue of accepted beats reduced at frame end).
module tb_logic_frame_accum;

  localparam int W  = 4;
  localparam int FL = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_xor;
  logic [W-1:0] out_and;
  logic [W-1:0] out_or;
  logic [11:0]  out_ones;
  logic [7:0]   out_count;

  logic_frame_accum #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xor   (out_xor),
    .out_and   (out_and),
    .out_or    (out_or),
    .out_ones  (out_ones),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: beats of the open frame and the presented summary.
  logic [W-1:0] beats[$];
  bit           m_hold;
  logic [W-1:0] m_xor, m_and, m_or;
  int           m_ones, m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    m_hold  = 1'b0;
    m_xor   = '0;
    m_and   = '0;
    m_or    = '0;
    m_ones  = 0;
    m_count = 0;
  endtask

  // Reduce the whole frame in one go from the list of accepted beats.
  task automatic model_close_frame();
    m_xor  = '0;
    m_and  = '1;
    m_or   = '0;
    m_ones = 0;
    foreach (beats[i]) begin
      m_xor  = m_xor ^ beats[i];
      m_and  = m_and & beats[i];
      m_or   = m_or | beats[i];
      m_ones = m_ones + $countones(beats[i]);
    end
    m_count = beats.size();
    beats.delete();
    m_hold = 1'b1;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (v) begin
      beats.push_back(d);
      if (l || beats.size() == FL) model_close_frame();
    end
  endtask

  task automatic compare_all();
    check("in_ready",  {31'd0, in_ready},  {31'd0, !m_hold});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    check("out_xor",   32'(out_xor),   32'(m_xor));
    check("out_and",   32'(out_and),   32'(m_and));
    check("out_or",    32'(out_or),    32'(m_or));
    check("out_ones",  32'(out_ones),  32'(m_ones));
    check("out_count", 32'(out_count), 32'(m_count));
  endtask

  // One cycle: drive at negedge, model the rising edge, compare at next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    model_edge(v, d, l, r);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic check_summary(input string tag, input logic [W-1:0] x, input logic [W-1:0] a,
                               input logic [W-1:0] o, input int n, input int c);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_xor"},   32'(out_xor),   32'(x));
    check({tag, "_and"},   32'(out_and),   32'(a));
    check({tag, "_or"},    32'(out_or),    32'(o));
    check({tag, "_ones"},  32'(out_ones),  32'(n));
    check({tag, "_count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Short frame.
    step(1'b1, 4'b1101, 1'b0, 1'b0);
    step(1'b1, 4'b0111, 1'b1, 1'b0);
    check_summary("short", 4'b1010, 4'b0101, 4'b1111, 6, 2);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Identical operands.
    step(1'b1, 4'b1010, 1'b0, 1'b1);
    step(1'b1, 4'b1010, 1'b1, 1'b1);
    check_summary("ident", 4'b0000, 4'b1010, 4'b1010, 4, 2);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Full frame without in_last.
    for (int i = 0; i < FL; i++) step(1'b1, 4'b0001, 1'b0, 1'b1);
    check_summary("full", 4'b0000, 4'b0001, 4'b0001, 8, 8);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Backpressure: beats offered during HOLD must be ignored.
    step(1'b1, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 1'b0, 1'b0);
    check_summary("bp", 4'b0011, 4'b0011, 4'b0011, 2, 1);
    step(1'b1, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 4'b0100, 1'b1, 1'b1);
    check_summary("bp_next", 4'b0100, 4'b0100, 4'b0100, 1, 1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b1);
    reset_pulse();
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    check_summary("rst", 4'b1111, 4'b1111, 4'b1111, 4, 1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // in_last coinciding with FRAME_LEN: one summary, no empty follow-on.
    for (int i = 0; i < FL; i++) step(1'b1, 4'b1000, (i == FL - 1), 1'b1);
    check_summary("lastfl", 4'b0000, 4'b1000, 4'b1000, 8, 8);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Single-beat all-zero frame.
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check_summary("single", 4'b0000, 4'b0000, 4'b0000, 0, 1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) reset_pulse();
      step(($urandom_range(3) != 0), W'($urandom), ($urandom_range(4) == 0),
           ($urandom_range(1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
